flopr_pipe: RTL

- Parametrised successor to the single resettable flip-flop: a STAGES-deep, N-bit-wide pipeline register chain.
- Each stage carries a valid bit. The chain supports global stall (enable), synchronous flush and an occupancy count.
- Used between datapath stages of the single-cycle-to-pipelined processor, e.g. IF/ID and ID/EX, or as a delay line.

---
 rtl/flopr_pipe.sv | 70 +++++++
 1 files changed

// File: rtl/flopr_pipe.sv
// STAGES-deep, N-bit pipeline register chain with per-stage valid bits,
// global stall, synchronous flush and an occupancy count of valid stages.
module flopr_pipe #(
    parameter  int N      = 64,
    parameter  int STAGES = 3,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [N-1:0]  d,
    input  logic          d_valid,
    output logic [N-1:0]  q,
    output logic          q_valid,
    output logic [CW-1:0] occupancy,
    output logic          empty
);

    logic [N-1:0]      data_q [STAGES];
    logic [N-1:0]      data_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        cnt_d  = cnt_q;
        if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                data_d[i] = '0;
            end
            v_d   = '0;
            cnt_d = '0;
        end else if (en) begin
            data_d[0] = d;
            v_d[0]    = d_valid;
            // Data moves regardless of its valid bit; bubbles keep their payload.
            for (int i = 1; i < STAGES; i++) begin
                data_d[i] = data_q[i-1];
                v_d[i]    = v_q[i-1];
            end
            cnt_d = cnt_q + CW'(d_valid) - CW'(v_q[STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign q         = data_q[STAGES-1];
    assign q_valid   = v_q[STAGES-1];
    assign occupancy = cnt_q;
    assign empty     = (cnt_q == '0);

endmodule
